// File: rtl/fetch_stall_ctrl.sv
// Fetch-stage sequencer: merges redirect and stall sources into one prioritised FSM and drives
// Moore controls into Fetch, plus a saturating stall-cycle counter and a sticky GPU-stall watchdog.
module fetch_stall_ctrl #(
    parameter int PC_WIDTH      = 16,
    parameter int GPU_STALL_MAX = 255,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                 I_CLOCK,
    input  logic                 I_RESET_N,
    input  logic                 I_LOCK,
    input  logic                 I_BranchAddrSelect,
    input  logic [PC_WIDTH-1:0]  I_BranchPC,
    input  logic                 I_BranchStallSignal,
    input  logic                 I_DepStallSignal,
    input  logic                 I_GPUStallSignal,
    output logic                 O_PCWrite,
    output logic                 O_IRHold,
    output logic                 O_FE_Valid,
    output logic                 O_Redirect,
    output logic [PC_WIDTH-1:0]  O_RedirectPC,
    output logic [2:0]           O_State,
    output logic [CNT_WIDTH-1:0] O_StallCycles,
    output logic                 O_GPUTimeout
);

    localparam int WD_W = $clog2(GPU_STALL_MAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_DEP    = 3'd2,
        ST_BRWAIT = 3'd3,
        ST_GPU    = 3'd4,
        ST_REDIR  = 3'd5
    } state_e;

    state_e                state_q, state_d;
    logic [PC_WIDTH-1:0]   redir_pc_q, redir_pc_d;
    logic [CNT_WIDTH-1:0]  stall_cnt_q, stall_cnt_d;
    logic [WD_W-1:0]       wd_cnt_q, wd_cnt_d;
    logic                  timeout_q, timeout_d;
    logic                  state_legal;
    logic                  in_stall_state;

    assign state_legal    = (state_q <= ST_REDIR);
    assign in_stall_state = (state_q == ST_DEP) || (state_q == ST_BRWAIT) || (state_q == ST_GPU);

    // Priority is the same from every legal state; illegal encodings fall back to IDLE.
    always_comb begin
        state_d = ST_IDLE;
        if (I_LOCK && state_legal) begin
            if (I_BranchAddrSelect)       state_d = ST_REDIR;
            else if (I_GPUStallSignal)    state_d = ST_GPU;
            else if (I_DepStallSignal)    state_d = ST_DEP;
            else if (I_BranchStallSignal) state_d = ST_BRWAIT;
            else                          state_d = ST_RUN;
        end
    end

    always_comb begin
        redir_pc_d = redir_pc_q;
        if (state_d == ST_REDIR) begin
            redir_pc_d = I_BranchPC;
        end
    end

    // The perf counter freezes while the pipeline is unlocked; the watchdog only counts unbroken GPU runs.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (I_LOCK && in_stall_state && (stall_cnt_q != {CNT_WIDTH{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_comb begin
        wd_cnt_d = '0;
        if (I_LOCK && (state_q == ST_GPU)) begin
            if (wd_cnt_q == WD_W'(GPU_STALL_MAX)) wd_cnt_d = wd_cnt_q;
            else                                  wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
        timeout_d = timeout_q | (wd_cnt_d == WD_W'(GPU_STALL_MAX));
    end

    always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            state_q     <= ST_IDLE;
            redir_pc_q  <= '0;
            stall_cnt_q <= '0;
            wd_cnt_q    <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            redir_pc_q  <= redir_pc_d;
            stall_cnt_q <= stall_cnt_d;
            wd_cnt_q    <= wd_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    // Moore decode straight from the state flop, so no input reaches an output combinationally.
    always_comb begin
        O_PCWrite  = 1'b0;
        O_IRHold   = 1'b1;
        O_FE_Valid = 1'b0;
        O_Redirect = 1'b0;
        case (state_q)
            ST_RUN: begin
                O_PCWrite  = 1'b1;
                O_IRHold   = 1'b0;
                O_FE_Valid = 1'b1;
            end
            ST_DEP, ST_GPU: begin
                O_IRHold   = 1'b1;
                O_FE_Valid = 1'b1;
            end
            ST_BRWAIT: begin
                O_IRHold   = 1'b0;
            end
            ST_REDIR: begin
                O_PCWrite  = 1'b1;
                O_IRHold   = 1'b0;
                O_Redirect = 1'b1;
            end
            default: begin
                O_PCWrite  = 1'b0;
                O_IRHold   = 1'b1;
            end
        endcase
    end

    assign O_RedirectPC  = redir_pc_q;
    assign O_State       = state_q;
    assign O_StallCycles = stall_cnt_q;
    assign O_GPUTimeout  = timeout_q;

endmodule

// File: tb/tb_fetch_stall_ctrl.sv
// Directed bench for fetch_stall_ctrl with small watchdog limit and narrow perf counter.
module tb_fetch_stall_ctrl;

    localparam int PC_WIDTH      = 16;
    localparam int GPU_STALL_MAX = 4;
    localparam int CNT_WIDTH     = 4;

    logic                 clk;
    logic                 rst_n;
    logic                 lock;
    logic                 addr_sel;
    logic [PC_WIDTH-1:0]  br_pc;
    logic                 br_stall;
    logic                 dep_stall;
    logic                 gpu_stall;
    logic                 pc_write;
    logic                 ir_hold;
    logic                 fe_valid;
    logic                 redirect;
    logic [PC_WIDTH-1:0]  redirect_pc;
    logic [2:0]           state;
    logic [CNT_WIDTH-1:0] stall_cycles;
    logic                 gpu_timeout;

    int pass_cnt  = 0;
    int total_cnt = 0;

    fetch_stall_ctrl #(
        .PC_WIDTH      (PC_WIDTH),
        .GPU_STALL_MAX (GPU_STALL_MAX),
        .CNT_WIDTH     (CNT_WIDTH)
    ) dut (
        .I_CLOCK             (clk),
        .I_RESET_N           (rst_n),
        .I_LOCK              (lock),
        .I_BranchAddrSelect  (addr_sel),
        .I_BranchPC          (br_pc),
        .I_BranchStallSignal (br_stall),
        .I_DepStallSignal    (dep_stall),
        .I_GPUStallSignal    (gpu_stall),
        .O_PCWrite           (pc_write),
        .O_IRHold            (ir_hold),
        .O_FE_Valid          (fe_valid),
        .O_Redirect          (redirect),
        .O_RedirectPC        (redirect_pc),
        .O_State             (state),
        .O_StallCycles       (stall_cycles),
        .O_GPUTimeout        (gpu_timeout)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // {state, PCWrite, IRHold, FE_Valid, Redirect}
    task automatic check_outs(input string tag, input logic [6:0] exp);
        check(tag, {25'd0, state, pc_write, ir_hold, fe_valid, redirect}, {25'd0, exp});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        lock      = 1'b0;
        addr_sel  = 1'b0;
        br_pc     = '0;
        br_stall  = 1'b0;
        dep_stall = 1'b0;
        gpu_stall = 1'b0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    localparam logic [6:0] O_IDLE   = {3'd0, 4'b0100};
    localparam logic [6:0] O_RUN    = {3'd1, 4'b1010};
    localparam logic [6:0] O_DEP    = {3'd2, 4'b0110};
    localparam logic [6:0] O_BRWAIT = {3'd3, 4'b0000};
    localparam logic [6:0] O_GPU    = {3'd4, 4'b0110};
    localparam logic [6:0] O_REDIR  = {3'd5, 4'b1001};

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        #1;
        check_outs("reset_outs", O_IDLE);
        check("reset_pc", 32'(redirect_pc), 32'h0);
        check("reset_cnt", 32'(stall_cycles), 32'd0);
        check("reset_timeout", 32'(gpu_timeout), 32'd0);
        #12;
        rst_n = 1'b1;

        // Test 1: lock with no stalls
        lock = 1'b1;
        step();
        check_outs("t1_run", O_RUN);

        // Test 2: branch stall then redirect
        br_stall = 1'b1;
        step(); check_outs("t2_brwait1", O_BRWAIT);
        step(); check_outs("t2_brwait2", O_BRWAIT);
        step(); check_outs("t2_brwait3", O_BRWAIT);
        addr_sel = 1'b1; br_pc = 16'h0040;
        step();
        check_outs("t2_redir", O_REDIR);
        check("t2_redir_pc", 32'(redirect_pc), 32'h0040);
        check("t2_cnt_redir", 32'(stall_cycles), 32'd3);
        addr_sel = 1'b0; br_stall = 1'b0; br_pc = 16'h0;
        step();
        check_outs("t2_run", O_RUN);
        check("t2_cnt", 32'(stall_cycles), 32'd3);
        check("t2_pc_hold", 32'(redirect_pc), 32'h0040);

        // Test 3: priority order
        dep_stall = 1'b1; br_stall = 1'b1;
        step(); check_outs("t3_dep", O_DEP);
        gpu_stall = 1'b1;
        step(); check_outs("t3_gpu", O_GPU);
        addr_sel = 1'b1; br_pc = 16'h1234;
        step();
        check_outs("t3_redir", O_REDIR);
        check("t3_redir_pc", 32'(redirect_pc), 32'h1234);
        addr_sel = 1'b0; br_pc = 16'h0;
        step();
        check_outs("t3_gpu_after_redir", O_GPU);
        check("t3_cnt", 32'(stall_cycles), 32'd5);
        gpu_stall = 1'b0; dep_stall = 1'b0; br_stall = 1'b0;
        addr_sel = 1'b1; br_pc = 16'hBEEF;
        step();
        check_outs("t3_redir_a", O_REDIR);
        check("t3_cnt_gpu_exit", 32'(stall_cycles), 32'd6);
        br_pc = 16'h0002;
        step();
        check_outs("t3_redir_b", O_REDIR);
        check("t3_relatch_pc", 32'(redirect_pc), 32'h0002);
        addr_sel = 1'b0; br_pc = 16'h0;
        step();
        check_outs("t3_run", O_RUN);
        check("t3_pc_hold", 32'(redirect_pc), 32'h0002);
        dep_stall = 1'b1;
        step(); check_outs("t3_dep2", O_DEP);
        lock = 1'b0;
        step();
        check_outs("t3_unlock_idle", O_IDLE);
        check("t3_unlock_cnt_hold", 32'(stall_cycles), 32'd6);
        addr_sel = 1'b1; br_pc = 16'h5555;
        step();
        check_outs("t3_unlock_no_redir", O_IDLE);
        check("t3_unlock_pc_hold", 32'(redirect_pc), 32'h0002);

        // Test 4a: watchdog run broken by one RUN cycle must restart
        apply_reset();
        lock = 1'b1; gpu_stall = 1'b1;
        step(); step(); step();
        gpu_stall = 1'b0;
        step(); check_outs("t4_break_run", O_RUN);
        gpu_stall = 1'b1;
        step(); step(); step(); step();
        check("t4_wd_restart", 32'(gpu_timeout), 32'd0);

        // Test 4b: sustained GPU stall trips the sticky watchdog
        apply_reset();
        lock = 1'b1; gpu_stall = 1'b1;
        step(); check_outs("t4_gpu_enter", O_GPU);
        step(); step(); step();
        check("t4_timeout_pre", 32'(gpu_timeout), 32'd0);
        step();
        check("t4_timeout_trip", 32'(gpu_timeout), 32'd1);
        check_outs("t4_gpu_stays", O_GPU);
        gpu_stall = 1'b0;
        step();
        check_outs("t4_run", O_RUN);
        check("t4_cnt", 32'(stall_cycles), 32'd5);
        step();
        check("t4_timeout_sticky", 32'(gpu_timeout), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t4_timeout_reset", 32'(gpu_timeout), 32'd0);
        #3;
        rst_n = 1'b1;

        // Test 5: perf counter saturation
        apply_reset();
        lock = 1'b1; dep_stall = 1'b1;
        for (int i = 0; i < 15; i++) step();
        check("t5_cnt14", 32'(stall_cycles), 32'd14);
        step();
        check("t5_cnt15", 32'(stall_cycles), 32'd15);
        for (int i = 0; i < 4; i++) step();
        check("t5_cnt_sat", 32'(stall_cycles), 32'd15);
        check_outs("t5_dep", O_DEP);

        // Test 6: async reset mid-REDIR
        apply_reset();
        lock = 1'b1; addr_sel = 1'b1; br_pc = 16'h0040;
        step();
        check_outs("t6_redir", O_REDIR);
        check("t6_pc", 32'(redirect_pc), 32'h0040);
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("t6_async_outs", O_IDLE);
        check("t6_async_pc", 32'(redirect_pc), 32'h0);
        check("t6_async_cnt", 32'(stall_cycles), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
